// File: rtl/arm_control_unit_pkg.sv
// Shared state encoding and datapath control codes
// for the ARM-subset control unit.
package arm_control_unit_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_DP,
    S_BL,
    S_BR,
    S_LS0,
    S_LD1,
    S_LD2,
    S_ST1,
    S_ST2,
    S_WB
  } state_e;

  localparam logic [1:0] MA_PC  = 2'b00;
  localparam logic [1:0] MA_RN  = 2'b01;
  localparam logic [1:0] MA_MDR = 2'b10;
  localparam logic [1:0] MA_RD  = 2'b11;

  localparam logic [1:0] MB_SHIFT = 2'b00;
  localparam logic [1:0] MB_FOUR  = 2'b01;
  localparam logic [1:0] MB_BOFF  = 2'b10;
  localparam logic [1:0] MB_ZERO  = 2'b11;

  localparam logic [1:0] MC_RD  = 2'b00;
  localparam logic [1:0] MC_R14 = 2'b01;
  localparam logic [1:0] MC_R15 = 2'b10;
  localparam logic [1:0] MC_RN  = 2'b11;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00100;
  localparam logic [4:0] OP_PASS_A = 5'b10000;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_WORD = 2'b10;

endpackage

// File: rtl/arm_cu_next_state.sv
// Combinational next-state logic of the control FSM.
// in: state, IR class/P/L bits, MOC, COND, clr; out: next state.
module arm_cu_next_state
  import arm_control_unit_pkg::*;
(
  input  state_e     state,
  input  logic       clr,
  input  logic [2:0] ir_class,
  input  logic       ir_p,
  input  logic       ir_l,
  input  logic       moc,
  input  logic       cond,
  output state_e     next
);

  always_comb begin
    next = S_FETCH0;
    if (clr) begin
      next = S_RESET;
    end else begin
      unique case (state)
        S_RESET:  next = S_FETCH0;
        S_FETCH0: next = S_FETCH1;
        S_FETCH1: next = S_FETCH2;
        S_FETCH2: next = moc ? S_FETCH3 : S_FETCH2;
        S_FETCH3: next = S_DECODE;
        S_DECODE: begin
          if (!cond)
            next = S_FETCH0;
          else if (ir_class[2:1] == 2'b00)
            next = S_DP;
          else if (ir_class[2:1] == 2'b01)
            next = S_LS0;
          else if (ir_class == 3'b101)
            next = ir_p ? S_BL : S_BR;
          else
            next = S_FETCH0;
        end
        S_DP:  next = S_FETCH0;
        S_BL:  next = S_BR;
        S_BR:  next = S_FETCH0;
        S_LS0: next = ir_l ? S_LD1 : S_ST1;
        S_LD1: next = moc ? S_LD2 : S_LD1;
        S_LD2: next = S_WB;
        S_ST1: next = S_ST2;
        S_ST2: next = moc ? S_WB : S_ST2;
        S_WB:  next = S_FETCH0;
        default: next = S_RESET;
      endcase
    end
  end

endmodule

// File: rtl/arm_control_unit.sv
// Moore control FSM for the ARM-subset CPU datapath.
// in: clk, clr, IR, MOC, COND, debug; out: load enables, mem strobes, mux selects, OP.
module arm_control_unit
  import arm_control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        COND,
  input  logic        debug,
  output logic        FR_ld,
  output logic        RF_ld,
  output logic        IR_ld,
  output logic        MAR_ld,
  output logic        MDR_ld,
  output logic        R_W,
  output logic        MOV,
  output logic [1:0]  MA,
  output logic [1:0]  MB,
  output logic [1:0]  MC,
  output logic        MD,
  output logic        ME,
  output logic [4:0]  OP,
  output logic [1:0]  DT
);

  state_e state;
  state_e next;

  logic ir_p, ir_u, ir_b, ir_w, ir_s;
  logic [1:0] dt_ls;
  logic [4:0] op_idx;
  logic wb_en;

  assign ir_p = IR[24];
  assign ir_u = IR[23];
  assign ir_b = IR[22];
  assign ir_w = IR[21];
  assign ir_s = IR[20];

  assign dt_ls  = ir_b ? DT_BYTE : DT_WORD;
  assign op_idx = ir_u ? OP_ADD : OP_SUB;
  // post-indexed transfers always write the base back
  assign wb_en  = ir_w | ~ir_p;

  // trace input has no hardware role
  logic unused_bits;
  assign unused_bits = ^{debug, IR[31:25], IR[19:0]};

  arm_cu_next_state u_next (
    .state    (state),
    .clr      (clr),
    .ir_class (IR[27:25]),
    .ir_p     (ir_p),
    .ir_l     (ir_s),
    .moc      (MOC),
    .cond     (COND),
    .next     (next)
  );

  always_ff @(posedge clk) begin
    state <= next;
  end

  always_comb begin
    FR_ld  = 1'b0;
    RF_ld  = 1'b0;
    IR_ld  = 1'b0;
    MAR_ld = 1'b0;
    MDR_ld = 1'b0;
    R_W    = 1'b0;
    MOV    = 1'b0;
    MA     = 2'b00;
    MB     = 2'b00;
    MC     = 2'b00;
    MD     = 1'b0;
    ME     = 1'b0;
    OP     = 5'b00000;
    DT     = 2'b00;
    unique case (state)
      S_RESET: begin
        RF_ld = 1'b1;
        MC    = MC_R15;
        MB    = MB_ZERO;
        OP    = OP_AND;
      end
      S_FETCH0: begin
        MAR_ld = 1'b1;
        MA     = MA_PC;
        OP     = OP_PASS_A;
      end
      S_FETCH1: begin
        RF_ld = 1'b1;
        MC    = MC_R15;
        MA    = MA_PC;
        MB    = MB_FOUR;
        OP    = OP_ADD;
        MOV   = 1'b1;
        R_W   = 1'b1;
        DT    = DT_WORD;
      end
      S_FETCH2: begin
        MOV    = 1'b1;
        R_W    = 1'b1;
        DT     = DT_WORD;
        MDR_ld = 1'b1;
        ME     = 1'b1;
      end
      S_FETCH3: IR_ld = 1'b1;
      S_DECODE: ;
      S_DP: begin
        MA    = MA_RN;
        MB    = MB_SHIFT;
        MC    = MC_RD;
        OP    = {1'b0, IR[24:21]};
        FR_ld = ir_s;
        // TST/TEQ/CMP/CMN only update flags
        RF_ld = (IR[24:23] != 2'b10);
      end
      S_BL: begin
        RF_ld = 1'b1;
        MC    = MC_R14;
        MA    = MA_PC;
        OP    = OP_PASS_A;
      end
      S_BR: begin
        RF_ld = 1'b1;
        MC    = MC_R15;
        MA    = MA_PC;
        MB    = MB_BOFF;
        OP    = OP_ADD;
      end
      S_LS0: begin
        MAR_ld = 1'b1;
        MA     = MA_RN;
        MB     = MB_SHIFT;
        OP     = ir_p ? op_idx : OP_PASS_A;
      end
      S_LD1: begin
        MOV    = 1'b1;
        R_W    = 1'b1;
        MDR_ld = 1'b1;
        ME     = 1'b1;
        DT     = dt_ls;
      end
      S_LD2: begin
        RF_ld = 1'b1;
        MC    = MC_RD;
        MA    = MA_MDR;
        OP    = OP_PASS_A;
      end
      S_ST1: begin
        MD     = 1'b1;
        MDR_ld = 1'b1;
        MA     = MA_RD;
        OP     = OP_PASS_A;
      end
      S_ST2: begin
        MOV = 1'b1;
        DT  = dt_ls;
      end
      S_WB: begin
        if (wb_en) begin
          RF_ld = 1'b1;
          MC    = MC_RN;
          MA    = MA_RN;
          MB    = MB_SHIFT;
          OP    = op_idx;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_control_unit.sv
// Randomized bench for arm_control_unit against
// a table-driven model of the instruction sequencer.
module tb_arm_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        MOC;
  logic        COND;
  logic        debug;
  logic        FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld;
  logic        R_W, MOV, MD, ME;
  logic [1:0]  MA, MB, MC, DT;
  logic [4:0]  OP;

  always #5 clk = ~clk;

  arm_control_unit dut (
    .clk    (clk),
    .clr    (clr),
    .IR     (IR),
    .MOC    (MOC),
    .COND   (COND),
    .debug  (debug),
    .FR_ld  (FR_ld),
    .RF_ld  (RF_ld),
    .IR_ld  (IR_ld),
    .MAR_ld (MAR_ld),
    .MDR_ld (MDR_ld),
    .R_W    (R_W),
    .MOV    (MOV),
    .MA     (MA),
    .MB     (MB),
    .MC     (MC),
    .MD     (MD),
    .ME     (ME),
    .OP     (OP),
    .DT     (DT)
  );

  typedef struct packed {
    logic fr, rf, irl, mar, mdr, rw, mov;
    logic [1:0] ma, mb, mc;
    logic md, me;
    logic [4:0] op;
    logic [1:0] dt;
  } ctl_t;

  typedef enum {
    M_RESET, M_F0, M_F1, M_F2, M_F3, M_DEC,
    M_DP, M_BL, M_BR, M_LS0, M_LD1, M_LD2,
    M_ST1, M_ST2, M_WB
  } mst_e;

  int n_cmp = 0;
  int n_bad = 0;

  ctl_t got;
  assign got = '{FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld,
                 R_W, MOV, MA, MB, MC, MD, ME, OP, DT};

  task automatic chk(input string tag,
                     input ctl_t obs, input ctl_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t m_out(mst_e s, logic [31:0] ir);
    ctl_t c = '0;
    logic [1:0] dt = ir[22] ? 2'b00 : 2'b10;
    logic [4:0] addsub = ir[23] ? 5'd4 : 5'd2;
    case (s)
      M_RESET: begin
        c.rf = 1; c.mc = 2; c.mb = 3; c.op = 0;
      end
      M_F0: begin c.mar = 1; c.op = 16; end
      M_F1: begin
        c.rf = 1; c.mc = 2; c.mb = 1; c.op = 4;
        c.mov = 1; c.rw = 1; c.dt = 2;
      end
      M_F2: begin
        c.mov = 1; c.rw = 1; c.dt = 2;
        c.mdr = 1; c.me = 1;
      end
      M_F3: c.irl = 1;
      M_DP: begin
        c.ma = 1; c.op = {1'b0, ir[24:21]};
        c.fr = ir[20];
        c.rf = !(ir[24] && !ir[23]);
      end
      M_BL: begin c.rf = 1; c.mc = 1; c.op = 16; end
      M_BR: begin
        c.rf = 1; c.mc = 2; c.mb = 2; c.op = 4;
      end
      M_LS0: begin
        c.mar = 1; c.ma = 1;
        c.op = ir[24] ? addsub : 5'd16;
      end
      M_LD1: begin
        c.mov = 1; c.rw = 1; c.mdr = 1;
        c.me = 1; c.dt = dt;
      end
      M_LD2: begin c.rf = 1; c.ma = 2; c.op = 16; end
      M_ST1: begin
        c.md = 1; c.mdr = 1; c.ma = 3; c.op = 16;
      end
      M_ST2: begin c.mov = 1; c.dt = dt; end
      M_WB: if (ir[21] || !ir[24]) begin
        c.rf = 1; c.mc = 3; c.ma = 1; c.op = addsub;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic mst_e m_next(mst_e s, logic [31:0] ir,
                                  bit moc, bit cnd, bit rst);
    if (rst) return M_RESET;
    case (s)
      M_RESET: return M_F0;
      M_F0:    return M_F1;
      M_F1:    return M_F2;
      M_F2:    return moc ? M_F3 : M_F2;
      M_F3:    return M_DEC;
      M_DEC: begin
        if (!cnd) return M_F0;
        if (ir[27:26] == 2'd0) return M_DP;
        if (ir[27:26] == 2'd1) return M_LS0;
        if (ir[27:25] == 3'b101) return ir[24] ? M_BL : M_BR;
        return M_F0;
      end
      M_BL:  return M_BR;
      M_LS0: return ir[20] ? M_LD1 : M_ST1;
      M_LD1: return moc ? M_LD2 : M_LD1;
      M_LD2: return M_WB;
      M_ST1: return M_ST2;
      M_ST2: return moc ? M_WB : M_ST2;
      default: return M_F0;
    endcase
  endfunction

  logic [31:0] ir_tab [10];
  mst_e ms;

  initial begin
    ir_tab = '{32'h01D00068, 32'hEB000004, 32'hEA000004,
               32'hE5B10004, 32'hE4910004, 32'hE5C10004,
               32'hE5210004, 32'hE1500001, 32'hE0010002,
               32'hEC000000};
    debug = 1'b0;
    clr   = 1'b1;
    MOC   = 1'b0;
    COND  = 1'b1;
    IR    = ir_tab[0];
    repeat (2) @(posedge clk);
    ms = M_RESET;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      chk(ms.name(), got, m_out(ms, IR));
      clr  = (i > 0) && ($urandom_range(0, 59) == 0);
      MOC  = ($urandom_range(0, 2) == 0);
      COND = ($urandom_range(0, 3) != 0);
      if (ms == M_F3) begin
        if ($urandom_range(0, 4) == 0)
          IR = $urandom;
        else
          IR = ir_tab[$urandom_range(0, 9)];
      end
      ms = m_next(ms, IR, MOC, COND, clr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_control_unit.md
Name: arm_control_unit

Overview:
- Microprogrammed-style Moore FSM that sequences the datapath of the ARM-subset CPU: fetch, decode and execute of data-processing, branch/branch-with-link and LDR/STR (word/byte) instructions.
- Drives load enables for the flag register, register file, IR, MAR and MDR.
- Drives the memory strobe (MOV, R_W, DT), the datapath mux selects and the 5-bit ALU opcode.
- Consumes the latched IR, the memory-done handshake MOC and the externally evaluated condition bit COND.

Parameters:
- None. State encoding, mux codes and ALU codes are fixed constants, listed under Decomposition.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- IR  in  32  current instruction (from the IR register).
- MOC  in  1  memory operation complete.
- COND  in  1  1 = IR[31:28] satisfied by the current flags.
- debug  in  1  simulation-only trace enable.
- FR_ld  out  1  load flag register.
- RF_ld  out  1  register-file write enable.
- IR_ld  out  1  load IR.
- MAR_ld  out  1  load MAR.
- MDR_ld  out  1  load MDR.
- R_W  out  1  1 = read, 0 = write.
- MOV  out  1  memory operation valid.
- MA  out  2  ALU-A select: 00 = PC (R15), 01 = Rn, 10 = MDR, 11 = Rd.
- MB  out  2  ALU-B select: 00 = shifter operand (imm12/shifted Rm/rotated imm8), 01 = constant 4, 10 = sign-extended imm24<<2, 11 = zero.
- MC  out  2  RF destination: 00 = Rd, 01 = R14, 10 = R15, 11 = Rn.
- MD  out  1  RF port-B address: 0 = Rm, 1 = Rd.
- ME  out  1  MDR source: 0 = ALU output, 1 = memory data.
- OP  out  5  ALU opcode.
- DT  out  2  memory data type: 00 = byte, 10 = word.

Behaviour:
- Single clock domain. On a rising edge with clr=1, state <= RESET, regardless of current state (reset mid-operation, including mid-wait, aborts it).
- Outputs are combinational from state and IR (Moore). Any output not listed for a state is 0.
- ALU OP codes: 0_xxxx = ARM data-processing opcode IR[24:21]; 00100 = ADD; 00010 = SUB; 00000 = AND; 10000 = pass A.
- RESET: RF_ld=1, MC=10, MB=11, OP=00000 (PC <= 0). Next state FETCH0.
- FETCH0: MAR_ld=1, MA=00, OP=10000. Next FETCH1.
- FETCH1: RF_ld=1, MC=10, MA=00, MB=01, OP=00100 (PC += 4); MOV=1, R_W=1, DT=10. Next FETCH2.
- FETCH2: MOV=1, R_W=1, DT=10, MDR_ld=1, ME=1. Stay while MOC=0; go to FETCH3 when MOC=1.
- FETCH3: IR_ld=1. Next DECODE.
- DECODE: all outputs 0. Transitions:
  - COND=0 -> FETCH0.
  - IR[27:26]=00 -> DP.
  - IR[27:26]=01 -> LS0.
  - IR[27:25]=101 -> BL if IR[24]=1, else BR.
  - Anything else -> FETCH0.
- DP: MA=01, MB=00, MC=00, OP={0,IR[24:21]}; FR_ld=IR[20]; RF_ld=1 unless IR[24:23]=10 (TST/TEQ/CMP/CMN write no register). Next FETCH0.
- BL: RF_ld=1, MC=01, MA=00, OP=10000 (R14 <= PC). Next BR.
- BR: RF_ld=1, MC=10, MA=00, MB=10, OP=00100. Next FETCH0.
- LS0: MAR_ld=1, MA=01, MB=00.
  - If IR[24] (P) =1: OP = 00100 when IR[23] (U) =1, else 00010.
  - If P=0: OP=10000.
  - Next LD1 if IR[20] (L) =1, else ST1.
- LD1: MOV=1, R_W=1, MDR_ld=1, ME=1, DT = 00 if IR[22], else 10. Wait here until MOC=1, then LD2.
- LD2: RF_ld=1, MC=00, MA=10, OP=10000. Next WB.
- ST1: MD=1, MDR_ld=1, ME=0, MA=11, OP=10000. Next ST2.
- ST2: MOV=1, R_W=0, DT as in LD1. Wait until MOC=1, then WB.
- WB: if IR[21] (W) =1 or P=0, then RF_ld=1, MC=11, MA=01, MB=00, OP = ADD/SUB per U; otherwise no loads. Next FETCH0.
- debug=1: on each rising clk, $display of state name and all outputs. No hardware effect.
- No MOC timeout; MOC sampled only in the wait states.

Decomposition:
- Shared package holds:
  - 4-bit state enum (15 states).
  - MA/MB/MC code constants.
  - ALU OP constants: AND, SUB, ADD, PASS_A.
  - DT constants.
- One natural sub-module, arm_cu_next_state: combinational next-state logic. Output decode stays in the top.

Test Plan:
- clr=1 for 2 edges, then 0 -> state RESET with RF_ld=1, MC=10, OP=00000; the next edge gives FETCH0 with MAR_ld=1, OP=10000.
- FETCH2 with MOC=0 for 3 cycles, then 1 -> MOV=1, R_W=1, DT=10 held throughout; IR_ld=1 exactly one cycle after MOC.
- IR=0x01D00068, COND=1 -> DP with OP=01110, FR_ld=1, RF_ld=1, MA=01, MB=00, MC=00; then FETCH0.
- Same IR, COND=0 -> DECODE goes straight to FETCH0; no RF_ld.
- IR=0xEB000004 (BL) -> BL with MC=01, then BR with MC=10, MB=10, OP=00100.
- IR=0xE5B10004 (LDR P=1, U=1, W=1) -> LS0 OP=00100; LD1 DT=10 waits on MOC; LD2 RF_ld=1, MC=00; WB MC=11. Assert clr during LD1 -> next state is RESET.
